regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file and shares it between two writeback sources.
- Source A is the main pipeline writeback; it cannot be back-pressured per write, only frozen. Source B is the long-latency unit (multdiv/FFT) and uses a valid/ready handshake.
- A 32-bit scoreboard tracks destinations issued to B. The block reports read hazards to decode and refuses issues that would cause a WAW conflict.
- Starvation guard: B is forced through after a bounded wait, and the displaced A write is parked in a one-entry hold register.

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter_pkg                                        |
// | Description : Shared constants and commit-source encoding for the          |
// |               register-file writeback arbiter and its scoreboard.          |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int NUM_REGS       = 32;
    localparam int DATA_WIDTH_DEF = 32;

    // Winner of the single regfile write port in a given cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_HOLD = 2'd1,
        SRC_A    = 2'd2,
        SRC_B    = 2'd3
    } src_e;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_scoreboard                                            |
// | Description : Busy-bit vector for destinations owned by the long-latency   |
// |               unit. One set port, one clear port, three lookups.           |
// | Ports       : clk_i/rst_i (async, active-high), set_en_i/set_idx_i,        |
// |               clr_en_i/clr_idx_i, iss/chk_a/chk_b lookup idx -> busy,      |
// |               busy_vec_o full vector.                                      |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_idx_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_idx_i,
    input  logic [REG_ADDR_W-1:0] iss_idx_i,
    input  logic [REG_ADDR_W-1:0] chk_a_idx_i,
    input  logic [REG_ADDR_W-1:0] chk_b_idx_i,
    output logic                  iss_busy_o,
    output logic                  chk_a_busy_o,
    output logic                  chk_b_busy_o,
    output logic [NUM_REGS-1:0]   busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set and clear never target the same index (issue is refused while the
    // bit is set), so their order here only matters for different indices.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i && (set_idx_i != '0)) begin
            busy_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign iss_busy_o   = busy_q[iss_idx_i];
    assign chk_a_busy_o = busy_q[chk_a_idx_i];
    assign chk_b_busy_o = busy_q[chk_b_idx_i];
    assign busy_vec_o   = busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter                                            |
// | Description : Shares the single 32x32 regfile write port between the      |
// |               pipeline writeback (A, freeze-only) and the long-latency     |
// |               unit (B, valid/ready). Tracks B destinations in a           |
// |               scoreboard, forces B through after STARVE_LIMIT cycles and   |
// |               parks the displaced A write in a one-entry hold register.    |
// | Ports       : clock, ctrl_reset (async high); a_* pipeline write;          |
// |               b_*/b_ready long-latency write; iss_*/iss_ready issue;       |
// |               chk_regA/B -> hazard; stall_pipe, proto_err, busy_vec;       |
// |               ctrl_writeEnable/ctrl_writeReg/data_writeReg regfile port.   |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_reg,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] chk_regA,
    input  logic [REG_ADDR_W-1:0] chk_regB,
    output logic                  hazard,
    output logic                  stall_pipe,
    output logic                  proto_err,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_WIDTH-1:0] data_writeReg
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] C_SAT   = {CNT_W{1'b1}};

    logic                  hold_full_q;
    logic [REG_ADDR_W-1:0] hold_reg_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  proto_err_q, proto_err_d;
    logic                  clr_pend_q;
    logic [REG_ADDR_W-1:0] clr_reg_q;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] wreg_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  iss_busy, chk_a_busy, chk_b_busy;
    logic                  a_ok, force_b, capture, b_xfer, b_owned;
    src_e                  sel;
    logic [REG_ADDR_W-1:0] commit_reg;
    logic [DATA_WIDTH-1:0] commit_data;

    // A is ignored while the pipeline is frozen; force mode needs an empty
    // hold slot to park A in.
    always_comb begin
        a_ok    = a_valid && !hold_full_q;
        force_b = b_valid && !hold_full_q && (wait_cnt_q >= C_LIMIT);
        if (hold_full_q) begin
            sel = SRC_HOLD;
        end else if (force_b) begin
            sel = SRC_B;
        end else if (a_ok) begin
            sel = SRC_A;
        end else if (b_valid) begin
            sel = SRC_B;
        end else begin
            sel = SRC_NONE;
        end
    end

    assign b_ready = (sel == SRC_B);
    assign b_xfer  = b_valid && b_ready;
    assign capture = force_b && a_valid;
    assign b_owned = busy_vec[b_reg];

    always_comb begin
        commit_reg  = hold_reg_q;
        commit_data = hold_data_q;
        case (sel)
            SRC_A: begin
                commit_reg  = a_reg;
                commit_data = a_data;
            end
            SRC_B: begin
                commit_reg  = b_reg;
                commit_data = b_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        wait_cnt_d = '0;
        if (b_valid && !b_ready) begin
            wait_cnt_d = (wait_cnt_q == C_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // Reg 0 is never marked busy, so a B result for it is a legitimate
    // completion of a reg-0 issue rather than an unowned write.
    assign proto_err_d = proto_err_q
                       || (a_valid && hold_full_q)
                       || (b_xfer && (b_reg != '0) && !b_owned);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            hold_full_q <= 1'b0;
            hold_reg_q  <= '0;
            hold_data_q <= '0;
            wait_cnt_q  <= '0;
            proto_err_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            clr_reg_q   <= '0;
            we_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            proto_err_q <= proto_err_d;

            if (sel == SRC_HOLD) begin
                hold_full_q <= 1'b0;
            end else if (capture) begin
                hold_full_q <= 1'b1;
                hold_reg_q  <= a_reg;
                hold_data_q <= a_data;
            end

            // The busy bit is released one cycle after the B commit, on the
            // edge where the regfile latches the write.
            clr_pend_q <= b_xfer && (b_reg != '0) && b_owned;
            clr_reg_q  <= b_reg;

            we_q <= (sel != SRC_NONE) && (commit_reg != '0);
            if (sel != SRC_NONE) begin
                wreg_q  <= commit_reg;
                wdata_q <= commit_data;
            end
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk_i        (clock),
        .rst_i        (ctrl_reset),
        .set_en_i     (iss_valid && iss_ready),
        .set_idx_i    (iss_reg),
        .clr_en_i     (clr_pend_q),
        .clr_idx_i    (clr_reg_q),
        .iss_idx_i    (iss_reg),
        .chk_a_idx_i  (chk_regA),
        .chk_b_idx_i  (chk_regB),
        .iss_busy_o   (iss_busy),
        .chk_a_busy_o (chk_a_busy),
        .chk_b_busy_o (chk_b_busy),
        .busy_vec_o   (busy_vec)
    );

    assign iss_ready        = !iss_busy;
    assign hazard           = (chk_a_busy && (chk_regA != '0)) || (chk_b_busy && (chk_regB != '0));
    assign stall_pipe       = hold_full_q;
    assign proto_err        = proto_err_q;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_wb_arbiter                                         |
// | Description : Self-checking bench for regfile_wb_arbiter: directed         |
// |               scenarios plus a randomized run against a cycle model.       |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int SL = 8;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          a_valid, b_valid, iss_valid;
    logic [4:0]    a_reg, b_reg, iss_reg, chk_regA, chk_regB;
    logic [DW-1:0] a_data, b_data;
    logic          b_ready, iss_ready, hazard, stall_pipe, proto_err;
    logic [31:0]   busy_vec;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [DW-1:0] data_writeReg;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL), .CNT_W(4)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .a_valid          (a_valid),
        .a_reg            (a_reg),
        .a_data           (a_data),
        .b_valid          (b_valid),
        .b_reg            (b_reg),
        .b_data           (b_data),
        .b_ready          (b_ready),
        .iss_valid        (iss_valid),
        .iss_reg          (iss_reg),
        .iss_ready        (iss_ready),
        .chk_regA         (chk_regA),
        .chk_regB         (chk_regB),
        .hazard           (hazard),
        .stall_pipe       (stall_pipe),
        .proto_err        (proto_err),
        .busy_vec         (busy_vec),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Inputs change at posedge+1, outputs are sampled at posedge+2.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        iss_valid = 0; iss_reg = 0; chk_regA = 0; chk_regB = 0;
    endtask

    task automatic do_reset();
        idle();
        ctrl_reset = 1;
        tick();
        tick();
        ctrl_reset = 0;
    endtask

    task automatic issue(input logic [4:0] r);
        iss_valid = 1; iss_reg = r;
        tick();
        iss_valid = 0;
    endtask

    // Drives A continuously against a waiting B until B is forced; returns
    // the cycle index of the force and the A write that got parked.
    task automatic starve(input logic [4:0] breg, output int n, output logic [4:0] preg,
                          output logic [DW-1:0] pdata);
        n = -1; preg = 0; pdata = 0;
        for (int k = 0; k < 20; k++) begin
            a_valid = 1; a_reg = 5'(10 + k % 5); a_data = 32'hA5A50000 + 32'(k);
            b_valid = 1; b_reg = breg; b_data = 32'h0B0B0000 + 32'(breg);
            #1;
            if (b_ready) begin
                n = k; preg = a_reg; pdata = a_data;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ctrl_writeEnable); end
        checks++; if (ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL reset_reg got %0d want 0", ctrl_writeReg); end
        checks++; if (data_writeReg !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_writeReg); end
        checks++; if (stall_pipe !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL reset_flags got stall=%b perr=%b want 0 0", stall_pipe, proto_err); end
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy_vec); end
    endtask

    task automatic test_a_write();
        a_valid = 1; a_reg = 3; a_data = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'hDEADBEEF) begin
            errors++; $display("FAIL a_write got we=%b reg=%0d data=%h want 1 3 deadbeef", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        tick();
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL a_write_idle got we=%b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_a_b_order();
        issue(5);
        a_valid = 1; a_reg = 4; a_data = 32'h44;
        b_valid = 1; b_reg = 5; b_data = 32'h55;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL ab_bready0 got %b want 0", b_ready); end
        tick();
        a_valid = 0;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL ab_bready1 got %b want 1", b_ready); end
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd4 || data_writeReg !== 32'h44) begin
            errors++; $display("FAIL ab_first got we=%b reg=%0d data=%h want 1 4 44", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        tick();
        idle();
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'h55) begin
            errors++; $display("FAIL ab_second got we=%b reg=%0d data=%h want 1 5 55", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL ab_busy_t1 got %h want 20", busy_vec); end
        tick();
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL ab_busy_t2 got %h want 0", busy_vec); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_reg = 7; chk_regA = 7;
        #1;
        checks++; if (iss_ready !== 1'b1 || hazard !== 1'b0) begin errors++; $display("FAIL sb_issue got rdy=%b haz=%b want 1 0", iss_ready, hazard); end
        tick();
        #1;
        checks++; if (iss_ready !== 1'b0 || hazard !== 1'b1) begin errors++; $display("FAIL sb_busy got rdy=%b haz=%b want 0 1", iss_ready, hazard); end
        tick();
        iss_valid = 0; chk_regA = 0; chk_regB = 7;
        b_valid = 1; b_reg = 7; b_data = 32'h77;
        #1;
        checks++; if (b_ready !== 1'b1 || hazard !== 1'b1) begin errors++; $display("FAIL sb_bcommit got rdy=%b haz=%b want 1 1", b_ready, hazard); end
        tick();
        b_valid = 0;
        #1;
        checks++; if (hazard !== 1'b1 || busy_vec !== 32'h80) begin errors++; $display("FAIL sb_t1 got haz=%b busy=%h want 1 80", hazard, busy_vec); end
        tick();
        #1;
        checks++; if (hazard !== 1'b0 || busy_vec !== 32'h0) begin errors++; $display("FAIL sb_t2 got haz=%b busy=%h want 0 0", hazard, busy_vec); end
        idle();
    endtask

    task automatic test_starvation();
        int n; logic [4:0] preg; logic [DW-1:0] pdata;
        issue(9);
        starve(9, n, preg, pdata);
        checks++; if (n != SL) begin errors++; $display("FAIL starve_cycle got %0d want %0d", n, SL); end
        tick();
        idle();
        #1;
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL starve_stall got %b want 1", stall_pipe); end
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9) begin errors++; $display("FAIL starve_bwrite got we=%b reg=%0d want 1 9", ctrl_writeEnable, ctrl_writeReg); end
        tick();
        #1;
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL starve_unstall got %b want 0", stall_pipe); end
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== preg || data_writeReg !== pdata) begin
            errors++; $display("FAIL starve_held got we=%b reg=%0d data=%h want 1 %0d %h", ctrl_writeEnable, ctrl_writeReg, data_writeReg, preg, pdata); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL starve_perr got %b want 0", proto_err); end
        tick();
    endtask

    task automatic test_proto_err();
        int n; logic [4:0] preg; logic [DW-1:0] pdata;
        issue(11);
        starve(11, n, preg, pdata);
        tick();
        b_valid = 0;
        a_valid = 1; a_reg = 14; a_data = 32'hBAD0BAD0;
        #1;
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL perr_stall got %b want 1", stall_pipe); end
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky cycle %0d got %b want 1", k, proto_err); end
            checks++; if (ctrl_writeEnable === 1'b1 && data_writeReg === 32'hBAD0BAD0) begin
                errors++; $display("FAIL perr_discard cycle %0d got data=%h want not bad0bad0", k, data_writeReg); end
            tick();
        end
    endtask

    task automatic test_reg0();
        do_reset();
        a_valid = 1; a_reg = 0; a_data = 32'h1234;
        tick();
        idle();
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reg0_a got we=%b want 0", ctrl_writeEnable); end
        iss_valid = 1; iss_reg = 0;
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reg0_iss got %b want 1", iss_ready); end
        tick();
        iss_valid = 0;
        b_valid = 1; b_reg = 0; b_data = 32'h5678;
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reg0_busy got %h want 0", busy_vec); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reg0_bready got %b want 1", b_ready); end
        tick();
        idle();
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reg0_b got we=%b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_async_reset();
        int n; logic [4:0] preg; logic [DW-1:0] pdata;
        do_reset();
        issue(7);
        starve(3, n, preg, pdata);
        tick();
        idle();
        #1;
        checks++; if (stall_pipe !== 1'b1 || busy_vec !== 32'h80) begin errors++; $display("FAIL arst_pre got stall=%b busy=%h want 1 80", stall_pipe, busy_vec); end
        #1 ctrl_reset = 1;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
            errors++; $display("FAIL arst_port got we=%b reg=%0d data=%h want 0 0 0", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        checks++; if (stall_pipe !== 1'b0 || proto_err !== 1'b0 || busy_vec !== 32'h0) begin
            errors++; $display("FAIL arst_state got stall=%b perr=%b busy=%h want 0 0 0", stall_pipe, proto_err, busy_vec); end
        tick();
        ctrl_reset = 0;
        tick();
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0 || stall_pipe !== 1'b0) begin errors++; $display("FAIL arst_after got we=%b stall=%b want 0 0", ctrl_writeEnable, stall_pipe); end
    endtask

    // Randomized run against a cycle model built from the arbitration rules.
    task automatic test_random(input int ncyc);
        bit            m_busy[32];
        bit            m_hold_full, m_we, m_perr, m_clr_pend;
        logic [4:0]    m_hold_reg, m_wreg, m_clr_reg;
        logic [DW-1:0] m_hold_data, m_wdata;
        int            m_wait, src, a_pct;
        int            outq[$];
        bit            gb_active, e_force, e_bready, e_iss, e_haz, old_busy, iss_acc;
        logic [4:0]    gb_reg, creg;
        logic [DW-1:0] gb_data, cdata;
        logic [31:0]   e_vec;

        do_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_hold_full = 0; m_we = 0; m_perr = 0; m_clr_pend = 0;
        m_hold_reg = 0; m_wreg = 0; m_clr_reg = 0; m_hold_data = 0; m_wdata = 0;
        m_wait = 0; gb_active = 0; gb_reg = 0; gb_data = 0;

        for (int c = 0; c < ncyc; c++) begin
            a_pct = ((c / 200) % 2 == 0) ? 95 : 45;
            a_valid  = !m_hold_full && ($urandom_range(0, 99) < a_pct);
            a_reg    = 5'($urandom_range(0, 31));
            a_data   = $urandom;
            if (!gb_active && outq.size() > 0 && $urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, outq.size() - 1);
                gb_reg = 5'(outq[idx]);
                outq.delete(idx);
                gb_data = $urandom;
                gb_active = 1;
            end
            b_valid   = gb_active; b_reg = gb_reg; b_data = gb_data;
            iss_valid = ($urandom_range(0, 99) < 30);
            iss_reg   = 5'($urandom_range(0, 31));
            chk_regA  = 5'($urandom_range(0, 31));
            chk_regB  = 5'($urandom_range(0, 31));

            e_force = (m_wait >= SL) && !m_hold_full && b_valid;
            if (m_hold_full) src = 1;
            else if (e_force) src = 3;
            else if (a_valid) src = 2;
            else if (b_valid) src = 3;
            else src = 0;
            e_bready = (src == 3);
            e_iss    = !m_busy[iss_reg];
            e_haz    = (chk_regA != 0 && m_busy[chk_regA]) || (chk_regB != 0 && m_busy[chk_regB]);
            for (int i = 0; i < 32; i++) e_vec[i] = m_busy[i];

            #1;
            checks++; if (b_ready !== e_bready) begin errors++; $display("FAIL rnd_bready cycle %0d got %b want %b", c, b_ready, e_bready); end
            checks++; if (iss_ready !== e_iss) begin errors++; $display("FAIL rnd_iss_ready cycle %0d got %b want %b", c, iss_ready, e_iss); end
            checks++; if (hazard !== e_haz) begin errors++; $display("FAIL rnd_hazard cycle %0d got %b want %b", c, hazard, e_haz); end
            checks++; if (busy_vec !== e_vec) begin errors++; $display("FAIL rnd_busy cycle %0d got %h want %h", c, busy_vec, e_vec); end
            checks++; if (stall_pipe !== m_hold_full || proto_err !== m_perr) begin
                errors++; $display("FAIL rnd_flags cycle %0d got stall=%b perr=%b want %b %b", c, stall_pipe, proto_err, m_hold_full, m_perr); end
            checks++; if (ctrl_writeEnable !== m_we) begin errors++; $display("FAIL rnd_we cycle %0d got %b want %b", c, ctrl_writeEnable, m_we); end
            if (m_we) begin
                checks++; if (ctrl_writeReg !== m_wreg || data_writeReg !== m_wdata) begin
                    errors++; $display("FAIL rnd_wport cycle %0d got reg=%0d data=%h want %0d %h", c, ctrl_writeReg, data_writeReg, m_wreg, m_wdata); end
            end

            // next state of the model
            creg = 0; cdata = 0;
            if (src == 1) begin creg = m_hold_reg; cdata = m_hold_data; end
            if (src == 2) begin creg = a_reg; cdata = a_data; end
            if (src == 3) begin creg = b_reg; cdata = b_data; end
            old_busy = m_busy[b_reg];
            iss_acc  = iss_valid && e_iss;
            if (src == 3 && b_reg != 0 && !old_busy) m_perr = 1;
            if (a_valid && m_hold_full) m_perr = 1;
            if (m_clr_pend) m_busy[m_clr_reg] = 0;
            if (iss_acc && iss_reg != 0) begin
                m_busy[iss_reg] = 1;
                outq.push_back(int'(iss_reg));
            end
            m_clr_pend = (src == 3) && (b_reg != 0) && old_busy;
            m_clr_reg  = b_reg;
            m_wait = (b_valid && src != 3) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
            if (src == 1) m_hold_full = 0;
            else if (e_force && a_valid) begin
                m_hold_full = 1; m_hold_reg = a_reg; m_hold_data = a_data;
            end
            m_we = (src != 0) && (creg != 0);
            if (src != 0) begin m_wreg = creg; m_wdata = cdata; end
            if (src == 3) gb_active = 0;
            tick();
        end
        idle();
    endtask

    initial begin
        ctrl_reset = 1;
        idle();
        test_reset();
        test_a_write();
        test_a_b_order();
        test_scoreboard();
        test_starvation();
        test_proto_err();
        test_reg0();
        test_async_reset();
        test_random(2000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
